// File: rtl/hex_scan_pkg.sv
// Shared constants, FSM state type and counter-width helper for the digit scanner.
// Pure declarations: no logic, no latency.
package hex_scan_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_ZERO   = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/hex_scan_mux_if.sv
// Decoded digit patterns in, multiplexed segment/anode bus out.
// Plain wires, no handshake: the scanner free-runs and never stalls.
interface hex_scan_mux_if;

  logic       enable;
  logic       lz_blank;
  logic [7:0] dp_mask;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       frame_tick;

  modport master (
    output enable, lz_blank, dp_mask,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  enable, lz_blank, dp_mask,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7,
    output seg, dp, an, frame_tick
  );

endinterface

// File: rtl/scan_prescaler.sv
// Slot counter 0..SCAN_DIV-1 with end-of-blank and end-of-slot pulses decoded from the count.
// Pulses are combinational from the registered count; clear_i holds the count at zero.
module scan_prescaler
  import hex_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int CW          = clog2(SCAN_DIV)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign blank_done_o = (cnt_q == CW'(BLANK_CYCLES - 1));
  assign slot_done_o  = (cnt_q == CW'(SCAN_DIV - 1));

  always_comb begin
    if (clear_i || slot_done_o) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_mux.sv
// Time-multiplexes eight snapshotted digit patterns onto one segment bus with blank time per slot.
// All outputs registered (change on the edge entering a state); no backpressure, free-running scan.
module hex_scan_mux
  import hex_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic           clk,
  input  logic           rst,
  hex_scan_mux_if.slave  bus
);

  logic [NUM_DIGITS-1:0][6:0] hex_in, snap_q, snap_d;
  logic [NUM_DIGITS-1:0]      snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]      blank_q, blank_d, lz_mask;
  state_e                     state_q, state_d;
  logic [2:0]                 digit_q, digit_d;
  logic [7:0]                 an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  logic                       tick_q, tick_d;
  logic                       take_snap;
  logic                       blank_done, slot_done;

  assign hex_in = {bus.HEX7, bus.HEX6, bus.HEX5, bus.HEX4,
                   bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};

  scan_prescaler #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (state_q == IDLE),
    .blank_done_o (blank_done),
    .slot_done_o  (slot_done)
  );

  // A digit is a leading zero only while every digit above it is also zero; digit 0 always shows.
  always_comb begin : lz_calc
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run        = run & (hex_in[k] == SEG_ZERO);
      lz_mask[k] = bus.lz_blank & run;
    end
  end

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    blank_d   = blank_q;
    take_snap = 1'b0;
    tick_d    = 1'b0;
    an_d      = 8'hFF;
    seg_d     = SEG_BLANK;
    dp_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          take_snap = 1'b1;
          digit_d   = 3'd0;
          state_d   = BLANK;
        end
      end
      BLANK: begin
        if (!bus.enable)     state_d = IDLE;
        else if (blank_done) state_d = DRIVE;
      end
      DRIVE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (slot_done) begin
          state_d = BLANK;
          digit_d = digit_q + 3'd1;
          if (digit_q == 3'd7) begin
            tick_d    = 1'b1;
            take_snap = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_snap) begin
      snap_d    = hex_in;
      snap_dp_d = bus.dp_mask;
      blank_d   = lz_mask;
    end

    // Outputs follow the next state so they switch on the same edge as the FSM.
    if (state_d == DRIVE) begin
      an_d  = blank_d[digit_d] ? 8'hFF : ~(8'd1 << digit_d);
      seg_d = snap_d[digit_d];
      dp_d  = ~snap_dp_d[digit_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      digit_q   <= 3'd0;
      snap_q    <= {NUM_DIGITS{SEG_BLANK}};
      snap_dp_q <= '0;
      blank_q   <= '0;
      an_q      <= 8'hFF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      blank_q   <= blank_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Randomized bench: a frame-time reference model queues expected outputs, a monitor compares every cycle.
module tb_hex_scan_mux;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 8 * SD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_scan_mux_if bus ();

  hex_scan_mux #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       mon_e, mon_a;
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [6:0] hex_v[8];

  assign bus.HEX0 = hex_v[0];
  assign bus.HEX1 = hex_v[1];
  assign bus.HEX2 = hex_v[2];
  assign bus.HEX3 = hex_v[3];
  assign bus.HEX4 = hex_v[4];
  assign bus.HEX5 = hex_v[5];
  assign bus.HEX6 = hex_v[6];
  assign bus.HEX7 = hex_v[7];

  // Reference model state: frame position and the snapshot the display is showing.
  bit         running = 0;
  int         t       = 0;
  logic [6:0] m_snap[8];
  logic [7:0] m_dp;
  bit         m_lz;
  int         m_msd;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic set_hex(input logic [31:0] val);
    for (int k = 0; k < 8; k++) hex_v[k] = seg7(val[4*k +: 4]);
  endtask

  task automatic take_snapshot();
    m_lz  = bus.lz_blank;
    m_dp  = bus.dp_mask;
    m_msd = 0;
    for (int k = 0; k < 8; k++) begin
      m_snap[k] = hex_v[k];
      if (hex_v[k] != 7'b0000001) m_msd = k;
    end
  endtask

  // Predict the outputs after the coming posedge from the inputs now applied, then wait a cycle.
  task automatic step();
    obs_t e;
    int   slot, ph;
    e = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
    if (rst) begin
      running = 0;
    end else if (!running) begin
      if (bus.enable) begin
        running = 1;
        t = 0;
        take_snapshot();
      end
    end else if (!bus.enable) begin
      running = 0;
    end else begin
      t++;
      if (t == FRAME) begin
        t = 0;
        take_snapshot();
        e.tick = 1'b1;
      end
    end
    if (running) begin
      slot = t / SD;
      ph   = t % SD;
      if (ph >= BC) begin
        e.seg = m_snap[slot];
        e.dp  = ~m_dp[slot];
        e.an  = (m_lz && slot > m_msd) ? 8'hFF : ~(8'd1 << slot);
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    int n;
    n = 0;
    while (!(running && t == target) && n < 4 * FRAME) begin
      step();
      n++;
    end
    checks++;
    if (n >= 4 * FRAME) begin
      failures++;
      $display("FAIL run_to: frame position %0d not reached, model t=%0d running=%0d", target, t, running);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    checks++;
    if (!$onehot0(~bus.an)) begin
      failures++;
      $display("FAIL onehot_an cycle %0d: an=%b has more than one anode low", cyc, bus.an);
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = '{an: bus.an, seg: bus.seg, dp: bus.dp, tick: bus.frame_tick};
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL outputs cycle %0d: got an=%h seg=%b dp=%b tick=%b, want an=%h seg=%b dp=%b tick=%b",
                 cyc, mon_a.an, mon_a.seg, mon_a.dp, mon_a.tick,
                 mon_e.an, mon_e.seg, mon_e.dp, mon_e.tick);
      end
    end
  end

  initial begin
    int r;
    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.lz_blank = 1'b0;
    bus.dp_mask  = 8'h00;
    set_hex(32'h0);
    repeat (3) step();
    rst = 1'b0;
    step();

    set_hex(32'h12345678);
    bus.dp_mask = 8'h10;
    bus.enable  = 1'b1;
    repeat (FRAME + 4) step();

    // Mid-frame change of HEX3 must wait for the next snapshot.
    run_to(SD + 3);
    hex_v[3] = seg7(4'hE);
    repeat (2 * FRAME) step();

    bus.lz_blank = 1'b1;
    set_hex(32'h000000A0);
    repeat (2 * FRAME) step();
    set_hex(32'h00000000);
    bus.dp_mask = 8'hC1;
    repeat (2 * FRAME) step();
    set_hex(32'h00102000);
    repeat (2 * FRAME) step();

    // Enable dropped while digit 5 is driven, then restarted.
    run_to(5 * SD + 4);
    bus.enable = 1'b0;
    repeat (3) step();
    set_hex(32'h9ABCDEF0);
    bus.enable = 1'b1;
    repeat (FRAME + 8) step();

    // Reset while digit 6 is driven.
    run_to(6 * SD + 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (FRAME + 8) step();

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 25)      set_hex($urandom >> (4 * $urandom_range(0, 8)));
      else if (r < 30) for (int k = 0; k < 8; k++) hex_v[k] = 7'($urandom);
      else if (r < 40) bus.dp_mask = 8'($urandom);
      else if (r < 45) bus.lz_blank = ~bus.lz_blank;
      else if (r < 48) bus.enable = ~bus.enable;
      else if (r < 49) rst = 1'b1;
      step();
      rst = 1'b0;
      if (!bus.enable && $urandom_range(0, 3) == 0) bus.enable = 1'b1;
    end

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_scan_mux.md
Name: hex_scan_mux

Overview:
Downstream consumer of the 8-digit seven-segment decoder. Takes the eight decoded digit patterns (HEX0..HEX7) and time-multiplexes them onto one shared segment bus with per-digit anode enables, for boards whose displays share segment lines. Provides anti-ghosting blank time, optional leading-zero suppression, per-digit decimal points and a frame strobe. All patterns of a frame come from one consistent snapshot.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (blank + drive); legal range 2..2^20
BLANK_CYCLES, 500, cycles per slot with all anodes off before driving; legal 1..SCAN_DIV-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = scan running, 0 = display dark
lz_blank  in  1  1 = suppress leading zero digits
dp_mask  in  8  bit k = light decimal point of digit k
HEX0..HEX7  in  7 each  active-low segment patterns from decoder, bit6=a .. bit0=g, HEXk = nibble k
seg  out  7  shared segment bus, active-low, same bit order
dp  out  1  decimal point, active-low
an  out  8  anode enables, active-low, an[k] = digit k
frame_tick  out  1  one-cycle pulse when digit 7 slot completes

Behaviour:
- Clock is clk; reset is synchronous and active-high (rst); every register is reset only on a rising clk edge with rst=1.
- Reset values: state=IDLE, digit=0, slot counter=0, an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, snapshot registers=7'h7F, blank mask=0.
- All outputs are registered; they take new values on the same edge that enters the corresponding state.
- States: IDLE, BLANK, DRIVE.
- IDLE: an=8'hFF, seg=7'h7F, dp=1. On enable=1: capture snapshot of HEX0..HEX7, dp_mask and compute blank mask; digit=0, counter=0; go BLANK.
- BLANK: an=8'hFF, seg=7'h7F, dp=1 for exactly BLANK_CYCLES cycles, then DRIVE.
- DRIVE: an = ~(1<<digit) unless blank_mask[digit]=1 (then an=8'hFF); seg=snap[digit]; dp=~snap_dp[digit]; lasts SCAN_DIV-BLANK_CYCLES cycles.
- End of DRIVE: if digit<7, digit+1, go BLANK. If digit=7: digit wraps to 0, frame_tick=1 for that one cycle, new snapshot captured on that same edge, go BLANK.
- Slot period exactly SCAN_DIV cycles; frame period exactly 8*SCAN_DIV cycles.
- Leading-zero mask (computed at snapshot): digit k (k=7..1) blanked iff lz_blank=1 and snap[j]==7'b0000001 for all j>=k. Digit 0 never blanked. A lit decimal point on digit k does not prevent zero blanking.
- Inputs changing mid-frame have no effect until next snapshot.
- enable=0 in BLANK or DRIVE: next edge go IDLE, outputs dark, no frame_tick. Re-enable restarts at digit 0 with fresh snapshot.
- rst mid-operation overrides everything: reset values on that edge.
- Exactly one anode (or none) low in any cycle; never two.

Decomposition:
- Package hex_scan_pkg: NUM_DIGITS=8, SEG_BLANK=7'h7F, SEG_ZERO=7'b0000001, state enum {IDLE, BLANK, DRIVE}, counter width function clog2(SCAN_DIV).
- One sub-module: scan_prescaler (slot counter; outputs blank_done and slot_done pulses, synchronous clear). FSM, snapshot and mux stay in hex_scan_mux.

Test Plan:
- SCAN_DIV=8, BLANK_CYCLES=2, rst held 3 cycles then enable=1 -> an=FF, seg=7F during reset; then per slot 2 cycles an=FF and 6 cycles an low; digit k driven in slot k; frame_tick pulses every 64 cycles, one cycle wide.
- HEX0..HEX7 = patterns of 0x12345678, dp_mask=8'h10 -> in slot k seg equals pattern of nibble k (slot 0 seg=7'b0000000 "8"); dp=0 only in slot 4.
- lz_blank=1, value 0x000000A0 -> digits 7..2 an=FF during DRIVE; digits 1 ("A") and 0 ("0") driven; value 0x00000000 -> only digit 0 driven.
- Change HEX3 mid-frame while in slot 1 -> slot 3 shows old pattern; new pattern appears in slot 3 of next frame after frame_tick.
- Drop enable during DRIVE of digit 5 -> next edge an=FF, seg=7F, no frame_tick; re-enable -> BLANK of digit 0 with fresh snapshot.
- Assert rst during DRIVE of digit 6 -> next edge all reset values; assertion check: $onehot0(~an) every cycle throughout.
